// File: rtl/sc_stream_sequencer.sv
// Sequencer for one stochastic-computing evaluation: loads the LFSR seed,
// runs the SC datapath for STREAM_LEN cycles and counts ones on its output.
module sc_stream_sequencer #(
   parameter int               WIDTH      = 8,
   parameter int               STREAM_LEN = 256,
   parameter int               CNT_W      = 9,
   parameter logic [WIDTH-1:0] SEED_SAFE  = WIDTH'(1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] seed_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] result,
   output logic [WIDTH-1:0] lfsr_seed,
   output logic             lfsr_load,
   output logic             lfsr_step,
   output logic [WIDTH-1:0] dp_b,
   output logic             fb_clr,
   input  logic             sc_bit
);

   localparam int LEN_W = (STREAM_LEN > 1) ? $clog2(STREAM_LEN) : 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WARM,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [LEN_W-1:0] len_cnt;
   logic [CNT_W-1:0] ones;
   logic             last;

   assign last = (len_cnt == LEN_W'(STREAM_LEN - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         lfsr_seed <= '0;
         lfsr_load <= 1'b0;
         lfsr_step <= 1'b0;
         dp_b      <= '0;
         fb_clr    <= 1'b0;
         len_cnt   <= '0;
         ones      <= '0;
      end else begin
         lfsr_load <= 1'b0;
         fb_clr    <= 1'b0;
         done      <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start && !abort) begin
                  state     <= LOAD;
                  busy      <= 1'b1;
                  lfsr_load <= 1'b1;
                  fb_clr    <= 1'b1;
                  dp_b      <= b_in;
                  lfsr_seed <= (seed_in == '0) ? SEED_SAFE : seed_in;
                  len_cnt   <= '0;
                  ones      <= '0;
               end
            end
            LOAD: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  state     <= WARM;
                  lfsr_step <= 1'b1;
               end
            end
            WARM: begin
               // feedback flop holds no valid bit yet; sc_bit ignored
               if (abort) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  lfsr_step <= 1'b0;
               end else begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (abort) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  lfsr_step <= 1'b0;
               end else begin
                  ones    <= ones + CNT_W'(sc_bit);
                  len_cnt <= len_cnt + LEN_W'(1);
                  if (last) begin
                     state     <= DONE;
                     lfsr_step <= 1'b0;
                     done      <= 1'b1;
                     result    <= ones + CNT_W'(sc_bit);
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               lfsr_step <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sc_stream_sequencer.sv
// Randomized bench for sc_stream_sequencer against a per-run ones-count
// model indexed by cycle offset from the accepted start.
module tb_sc_stream_sequencer;

   localparam int W  = 8;
   localparam int L  = 256;
   localparam int CW = 9;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic [W-1:0]  seed_in;
   logic [W-1:0]  b_in;
   logic          busy;
   logic          done;
   logic [CW-1:0] result;
   logic [W-1:0]  lfsr_seed;
   logic          lfsr_load;
   logic          lfsr_step;
   logic [W-1:0]  dp_b;
   logic          fb_clr;
   logic          sc_bit;

   int n_checks = 0;
   int n_errors = 0;
   int exp_result = 0;
   logic [W-1:0] cur_seed = '0;
   logic [W-1:0] cur_b = '0;

   sc_stream_sequencer #(
      .WIDTH(W),
      .STREAM_LEN(L),
      .CNT_W(CW),
      .SEED_SAFE(8'h01)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .abort(abort),
      .seed_in(seed_in),
      .b_in(b_in),
      .busy(busy),
      .done(done),
      .result(result),
      .lfsr_seed(lfsr_seed),
      .lfsr_load(lfsr_load),
      .lfsr_step(lfsr_step),
      .dp_b(dp_b),
      .fb_clr(fb_clr),
      .sc_bit(sc_bit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_load"}, 32'(lfsr_load), 0);
      chk({tag, "_step"}, 32'(lfsr_step), 0);
      chk({tag, "_clr"}, 32'(fb_clr), 0);
      chk({tag, "_res"}, 32'(result), 32'(exp_result));
      chk({tag, "_seed"}, 32'(lfsr_seed), 32'(cur_seed));
      chk({tag, "_b"}, 32'(dp_b), 32'(cur_b));
   endtask

   // mode: 0 random, 1 all ones, 2 all zeros, 3 odd RUN cycles + WARM
   task automatic run(input int mode, input logic [W-1:0] sd,
                      input logic [W-1:0] bb, input int abort_at,
                      input int rst_at);
      int ones = 0;
      @(negedge clk);
      start   = 1'b1;
      abort   = 1'b0;
      seed_in = sd;
      b_in    = bb;
      sc_bit  = 1'($urandom);
      @(negedge clk);
      cur_seed = (sd == '0) ? 8'h01 : sd;
      cur_b    = bb;
      seed_in  = W'($urandom);
      b_in     = W'($urandom);
      for (int k = 1; k <= L + 4; k++) begin
         if (rst_at == k) begin
            rst = 1'b1;
            #1;
            exp_result = 0;
            cur_seed   = '0;
            cur_b      = '0;
            check_idle("async_rst");
            start = 1'b0;
            abort = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         if (abort_at > 0 && k == abort_at + 1) begin
            abort = 1'b0;
            start = 1'b0;
            check_idle("abort");
            for (int j = 0; j < 6; j++) begin
               @(negedge clk);
               chk("abort_nodone", 32'(done), 0);
            end
            return;
         end
         if (k == L + 3) exp_result = ones;
         chk("busy", 32'(busy), 32'(k <= L + 3));
         chk("done", 32'(done), 32'(k == L + 3));
         chk("load", 32'(lfsr_load), 32'(k == 1));
         chk("fb_clr", 32'(fb_clr), 32'(k == 1));
         chk("step", 32'(lfsr_step), 32'(k >= 2 && k <= L + 2));
         chk("dp_b", 32'(dp_b), 32'(cur_b));
         chk("seed", 32'(lfsr_seed), 32'(cur_seed));
         chk("result", 32'(result), 32'(exp_result));
         if (k == L + 3) begin
            if (mode == 1) chk("cnt_ones", 32'(result), 256);
            if (mode == 2) chk("cnt_zeros", 32'(result), 0);
            if (mode == 3) chk("cnt_odd", 32'(result), 128);
         end
         unique case (mode)
            1: sc_bit = 1'b1;
            2: sc_bit = 1'b0;
            3: sc_bit = (k == 2) || (k >= 3 && ((k - 2) % 2) == 1);
            default: sc_bit = 1'($urandom);
         endcase
         if (k >= 3 && k <= L + 2) ones += int'(sc_bit);
         start = (k <= L + 2) ? 1'($urandom) : 1'b0;
         abort = (k == abort_at) || (k == L + 3);
         if (k == L + 4) abort = 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      abort   = 1'b0;
      seed_in = 8'h33;
      b_in    = 8'h44;
      sc_bit  = 1'b1;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      repeat (5) @(negedge clk);
      run(1, 8'h5a, 8'h40, 0, 0);
      run(2, 8'hc3, 8'h11, 0, 0);
      run(3, 8'h01, 8'hfe, 0, 0);
      run(0, 8'h00, 8'h80, 0, 0);
      run(1, 8'h77, 8'h20, 0, 0);
      run(0, 8'h9b, 8'h31, 12, 0);
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check_idle("start_abort");
      run(0, 8'h12, 8'h34, 0, 100);
      run(3, 8'h56, 8'h78, 0, 0);
      for (int i = 0; i < 3; i++)
         run(0, W'($urandom), W'($urandom), 0, 0);
      repeat (3) @(negedge clk);
      check_idle("final");
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
